// File: rtl/hilo_pkg.sv
// Shared types, op encodings and helpers for the HI/LO multiply/divide unit.
// Optional multiply-accumulate ops are enabled by defining HILO_MADD_EN.
package hilo_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ITER_CNT = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MADDU = 3'b101,
        OP_MTHI  = 3'b110,
        OP_MTLO  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    endfunction

    // Ops that run through the iterative datapath and raise busy
    function automatic logic is_arith_op(input op_e op);
`ifdef HILO_MADD_EN
        return (op != OP_MTHI) && (op != OP_MTLO);
`else
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
`endif
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic neg);
        return neg ? DATA_W'(-v) : v;
    endfunction

endpackage

// File: rtl/hilo_if.sv
// Request/result bundle between an issuing pipeline and the HI/LO unit.
interface hilo_if;
    import hilo_pkg::*;

    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic              cancel;
    logic              busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (output start, op, rs, rt, cancel, input  busy, hi, lo);
    modport slave  (input  start, op, rs, rt, cancel, output busy, hi, lo);

endinterface

// File: rtl/hilo_iter_core.sv
// One-bit-per-step datapath: unsigned shift-add multiply or restoring divide
// on magnitudes; acc/shift registers read out as raw {hi,lo}.
module hilo_iter_core
    import hilo_pkg::*;
#(
    parameter int unsigned W = DATA_W
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_en,
    input  logic         i_is_div,
    input  logic [W-1:0] i_rs,
    input  logic [W-1:0] i_rt,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    logic         r_is_div;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_sh;
    logic [W-1:0] r_opnd;

    logic [W:0]   w_sum;
    logic [W:0]   w_shift;
    logic         w_ge;
    logic [W-1:0] w_sub;
    logic [W-1:0] w_acc_nx;
    logic [W-1:0] w_sh_nx;

    // Multiply: acc accumulates multiplicand, multiplier shifts out of sh.
    // Divide: sh shifts dividend bits into acc, quotient bits shift into sh.
    always_comb begin
        w_sum    = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
        w_shift  = {r_acc, r_sh[W-1]};
        w_ge     = (w_shift >= {1'b0, r_opnd});
        w_sub    = W'(w_shift - {1'b0, r_opnd});
        w_acc_nx = w_sum[W:1];
        w_sh_nx  = {w_sum[0], r_sh[W-1:1]};
        if (r_is_div) begin
            w_acc_nx = w_ge ? w_sub : w_shift[W-1:0];
            w_sh_nx  = {r_sh[W-2:0], w_ge};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_div <= 1'b0;
            r_acc    <= '0;
            r_sh     <= '0;
            r_opnd   <= '0;
        end else if (i_load) begin
            r_is_div <= i_is_div;
            r_acc    <= '0;
            r_sh     <= i_is_div ? i_rs : i_rt;
            r_opnd   <= i_is_div ? i_rt : i_rs;
        end else if (i_en) begin
            r_acc    <= w_acc_nx;
            r_sh     <= w_sh_nx;
        end
    end

    assign o_hi = r_acc;
    assign o_lo = r_sh;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO unit: FSM, operand capture, sign fixup and architectural HI/LO.
// Define HILO_MADD_EN to enable MADD/MADDU (accumulate into {hi,lo} in FIX).
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned XLEN = 32
)
(
    input  logic  clk,
    input  logic  rst_n,
    hilo_if.slave bus
);

    localparam int unsigned W     = XLEN;
    localparam int unsigned P_W   = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(ITER_CNT);

    state_e           r_state;
    state_e           w_next;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    op_e              r_op;
    logic             r_neg_a;
    logic             r_neg_b;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;

    op_e              w_op;
    logic             w_sgn;
    logic             w_load;
    logic             w_en;
    logic             w_fix_wr;
    logic             w_mv_hi;
    logic             w_mv_lo;
    logic [W-1:0]     w_core_hi;
    logic [W-1:0]     w_core_lo;
    logic [P_W-1:0]   w_prod;
    logic [W-1:0]     w_quo;
    logic [W-1:0]     w_rem;
    logic [P_W-1:0]   w_res;

    assign w_op  = op_e'(bus.op);
    assign w_sgn = is_signed_op(w_op);

    hilo_iter_core #(.W(W)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_en     (w_en),
        .i_is_div (is_div_op(w_op)),
        .i_rs     (magnitude(bus.rs, w_sgn & bus.rs[W-1])),
        .i_rt     (magnitude(bus.rt, w_sgn & bus.rt[W-1])),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    // Next-state and control; cancel wins over both a new start and the FIX write
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_en     = 1'b0;
        w_fix_wr = 1'b0;
        w_mv_hi  = 1'b0;
        w_mv_lo  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    if (is_arith_op(w_op)) begin
                        w_load = 1'b1;
                        w_next = ST_CALC;
                    end else begin
                        w_mv_hi = (w_op == OP_MTHI);
                        w_mv_lo = (w_op == OP_MTLO);
                    end
                end
            end
            ST_CALC: begin
                if (bus.cancel) begin
                    w_next = ST_IDLE;
                end else begin
                    w_en = 1'b1;
                    if (r_cnt == CNT_W'(ITER_CNT - 1)) w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_next   = ST_IDLE;
                w_fix_wr = !bus.cancel;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_op    <= OP_MULT;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
        end else if (w_load) begin
            r_cnt   <= '0;
            r_op    <= w_op;
            r_neg_a <= w_sgn & bus.rs[W-1];
            r_neg_b <= w_sgn & bus.rt[W-1];
        end else if (w_en) begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Sign fixup: product/quotient negated on differing signs, remainder follows dividend
    always_comb begin
        w_prod = {w_core_hi, w_core_lo};
        if (r_neg_a ^ r_neg_b) w_prod = -w_prod;
        w_quo  = (r_neg_a ^ r_neg_b) ? -w_core_lo : w_core_lo;
        w_rem  = r_neg_a ? -w_core_hi : w_core_hi;
        w_res  = w_prod;
        if (is_div_op(r_op)) begin
            w_res = {w_rem, w_quo};
        end
`ifdef HILO_MADD_EN
        else if ((r_op == OP_MADD) || (r_op == OP_MADDU)) begin
            w_res = {r_hi, r_lo} + w_prod;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix_wr) begin
            r_hi <= w_res[P_W-1:W];
            r_lo <= w_res[W-1:0];
        end else begin
            if (w_mv_hi) r_hi <= bus.rs;
            if (w_mv_lo) r_lo <= bus.rs;
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: stimulus queues hand-computed HI/LO and busy
// durations; a negedge monitor checks them on busy fall or on a probe request.
module tb_hilo_unit;
    import hilo_pkg::*;

    typedef struct {
        int          id;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;   // expected busy-high cycles, -1 = don't check
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_if u_if();

    hilo_unit #(.XLEN(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    exp_t sb_q[$];
    int   n_chk     = 0;
    int   n_pass    = 0;
    int   probe_req = 0;

    function automatic void chk(input string nm, input int id,
                                input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s id=%0d: got %h expected %h", nm, id, act, req);
    endfunction

    // Monitor: compare when busy falls or when the stimulus asks for a probe
    initial begin
        exp_t e;
        logic prev;
        int   cyc;
        prev = 1'b0;
        cyc  = 0;
        forever begin
            @(negedge clk);
            if (u_if.busy === 1'b1) begin
                cyc++;
            end else if (prev || probe_req > 0) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: hi=%h lo=%h with empty scoreboard", u_if.hi, u_if.lo);
                end else begin
                    e = sb_q.pop_front();
                    chk("hi", e.id, u_if.hi, e.hi);
                    chk("lo", e.id, u_if.lo, e.lo);
                    if (e.cyc >= 0) chk("busy_cycles", e.id, 32'(cyc), 32'(e.cyc));
                end
                if (!prev && probe_req > 0) probe_req--;
                cyc = 0;
            end
            prev = (u_if.busy === 1'b1);
        end
    end

    task automatic expect_out(input int id, input logic [31:0] hi,
                              input logic [31:0] lo, input int cyc);
        exp_t e;
        e.id = id; e.hi = hi; e.lo = lo; e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        u_if.op = o; u_if.rs = a; u_if.rt = b; u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb_q.size() != 0 || u_if.busy !== 1'b0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (k >= 200) begin
            n_chk++;
            $display("FAIL timeout: %0d expectations still pending", sb_q.size());
            sb_q.delete();
            probe_req = 0;
        end
    endtask

    task automatic run_op(input int id, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        expect_out(id, hi, lo, 33);
        issue(o, a, b);
        drain();
    endtask

    task automatic run_move(input int id, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] hi, input logic [31:0] lo);
        expect_out(id, hi, lo, 0);
        issue(o, a, 32'h0);
        probe_req++;
        drain();
    endtask

    initial begin
        u_if.start = 1'b0; u_if.cancel = 1'b0;
        u_if.op = 3'b000; u_if.rs = '0; u_if.rt = '0;

        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        expect_out(0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1 probe_req++;
        drain();

        run_op(1, OP_MULT,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(2, OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE);
        run_op(3, OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(4, OP_DIVU,  32'h7,         32'h0,         32'h0000_0007, 32'hFFFF_FFFF);
        run_op(5, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op(6, OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F);
        run_op(7, OP_DIV,   32'h7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

        run_move(8,  OP_MTHI, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFD);
        run_move(9,  OP_MTLO, 32'h5,         32'h1234_5678, 32'h5);
        run_move(10, OP_MTHI, 32'h0,         32'h0,         32'h5);

`ifdef HILO_MADD_EN
        run_op(11, OP_MADD, 32'h3, 32'h4, 32'h0, 32'h11);
`else
        expect_out(11, 32'h0, 32'h5, 0);
        issue(OP_MADD, 32'h3, 32'h4);
        probe_req++;
        drain();
`endif

        // DIV 100/7 with an intruding MTHI and operand churn while busy
        expect_out(12, 32'h2, 32'hE, 33);
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        u_if.op = OP_MTHI; u_if.rs = 32'hDEAD_BEEF; u_if.rt = 32'h1; u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        u_if.op = OP_MULTU; u_if.rs = 32'hFFFF_FFFF; u_if.rt = 32'hFFFF_FFFF;
        drain();

        // Cancel during CALC: busy drops after 11 cycles, HI/LO untouched
        expect_out(13, 32'h2, 32'hE, 11);
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        repeat (10) @(posedge clk);
        @(negedge clk) u_if.cancel = 1'b1;
        @(posedge clk);
        #1 u_if.cancel = 1'b0;
        drain();

        // Cancel coincident with start in IDLE rejects both move and arith ops
        expect_out(14, 32'h2, 32'hE, 0);
        @(negedge clk) u_if.cancel = 1'b1;
        issue(OP_MTHI, 32'hAAAA_AAAA, 32'h0);
        u_if.cancel = 1'b0;
        probe_req++;
        drain();
        expect_out(15, 32'h2, 32'hE, 0);
        @(negedge clk) u_if.cancel = 1'b1;
        issue(OP_DIV, 32'd9, 32'd2);
        u_if.cancel = 1'b0;
        probe_req++;
        drain();

        // Asynchronous reset mid-DIV, then a start on the first edge after release
        expect_out(16, 32'h0, 32'h0, -1);
        issue(OP_DIV, 32'd50, 32'd3);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        expect_out(17, 32'h0, 32'h2A, 33);
        @(negedge clk);
        rst_n = 1'b1;
        u_if.op = OP_MULTU; u_if.rs = 32'd6; u_if.rt = 32'd7; u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
